output_packer: RTL and testbench
================================

OUTPUT_PACKER -- requirements
Module: output_packer

Interface
REQ-001 The module SHALL have parameter numElements, default 32, meaning output channels per scaled vector.
REQ-002 The module SHALL have parameter elementBits, default 8, meaning the width of each scaled element on data_i.
REQ-003 The module SHALL have parameter addrWidth, default 32, meaning the byte-address width of the activation buffer.
REQ-004 The module SHALL have parameter countWidth, default 16, meaning the width of the vector counter.
REQ-005 The module SHALL derive wordBits = numElements*elementBits and wordBytes = wordBits/8 as localparams.
REQ-006 Port list, in order:
- clk  in  1  clock, single clock domain.
- nrst  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; latches cfg and begins a job.
- clear_i  in  1  synchronous abort to IDLE.
- cfg_out_bits_i  in  4  packed element width, legal values 2/4/8.
- cfg_base_addr_i  in  addrWidth  byte address of the first write.
- cfg_num_vectors_i  in  countWidth  vectors in the job.
- valid_i  in  1  scaled vector valid.
- data_i  in  wordBits  element e at [e*elementBits +: elementBits].
- ready_o  out  1  vector accepted when valid_i&&ready_o.
- wr_en_o  out  1  buffer write strobe.
- wr_addr_o  out  addrWidth  buffer byte address.
- wr_data_o  out  wordBits  packed word.
- busy_o  out  1  high in RUN or FLUSH.
- done_o  out  1  one-cycle job-complete pulse.

Function
REQ-007 The module SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-008 In IDLE, start_i SHALL latch all cfg inputs and go to RUN; if cfg_num_vectors_i==0 it SHALL go directly to DONE with no writes.
REQ-009 An illegal cfg_out_bits_i value (not 2, 4 or 8) SHALL be treated as 8.
REQ-010 The module SHALL derive vectors-per-word P = 8/n, where n is the latched width: P=1, 2 or 4.
REQ-011 ready_o SHALL equal 1 only in RUN; valid_i outside RUN SHALL be ignored.
REQ-012 Each accepted vector SHALL be compressed to numElements*n bits: element e contributes its n LSBs at [e*n +: n].
REQ-013 Accepted vector k within a word (k = 0..P-1) SHALL occupy word bits [k*numElements*n +: numElements*n], LSB-first.
REQ-014 When the P-th vector of a word is accepted, the next cycle SHALL present wr_en_o=1 with the complete word. Latency is 1 cycle; outputs are registered.
REQ-015 wr_addr_o SHALL start at the base address and increase by wordBytes after each write, wrapping modulo 2^addrWidth.
REQ-016 When the last vector (count==cfg_num_vectors) is accepted, a partially filled word SHALL be written in the next cycle with unfilled bits zero.
REQ-017 After the last vector's write, the FSM SHALL pass through FLUSH for 1 cycle with wr_en_o=0, then enter DONE.
REQ-018 DONE SHALL assert done_o for exactly 1 cycle, then return to IDLE.
REQ-019 wr_en_o SHALL be high for exactly 1 cycle per write. The total writes per job SHALL be ceil(N/P).
REQ-020 start_i while not IDLE SHALL be ignored.
REQ-021 clear_i SHALL force IDLE next cycle from any state, zeroing the pack register, counters and wr_en_o, with no done_o pulse. clear_i SHALL win over a simultaneous start_i.
REQ-022 Gaps in valid_i SHALL stall packing without losing partial-word content.

Reset
REQ-023 On nrst=0, all state SHALL reset asynchronously: state=IDLE; ready_o, wr_en_o, busy_o and done_o = 0; wr_addr_o, wr_data_o, counters and latched cfg = 0.
REQ-024 Reset mid-job SHALL discard the partial word; no write SHALL be issued after reset release until a new start_i.

Verification
REQ-025 Width 8, base 0x100, N=3, vectors of all 0x11/0x22/0x33 -> three writes at 0x100/0x120/0x140 with data all-0x11/all-0x22/all-0x33, then done_o one pulse.
REQ-026 Width 4, N=3, vectors with every element 0xA5, 0x03 and 0x0F -> write 1: lower 128b all 0x5, upper 128b all 0x3; write 2: lower 128b all 0xF, upper zero; addresses base and base+32.
REQ-027 Width 2, N=4, valid_i toggling every other cycle -> exactly one write, one cycle after the 4th accept, with vector k in bits [64k +: 64].
REQ-028 N=0 -> no wr_en_o, done_o one cycle after start_i; cfg_out_bits_i=5 behaves identically to 8.
REQ-029 clear_i asserted after 1 of 2 vectors at width 4, together with start_i -> no write, no done_o, IDLE; a subsequent job starts cleanly at its base address.
REQ-030 nrst pulsed mid-job -> all outputs 0 immediately; base address 0xFFFFFFE0 with N=2 at width 8 -> writes at 0xFFFFFFE0 then 0x00000000.

Source files
------------

// File: rtl/output_packer.sv
// Packs scaled activation vectors into buffer words, compressing each element to
// 2, 4 or 8 bits and issuing one registered write per full or final partial word.
module output_packer #(
    parameter int numElements = 32,
    parameter int elementBits = 8,
    parameter int addrWidth   = 32,
    parameter int countWidth  = 16,
    localparam int wordBits   = numElements * elementBits,
    localparam int wordBytes  = wordBits / 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic [3:0]            cfg_out_bits_i,
    input  logic [addrWidth-1:0]  cfg_base_addr_i,
    input  logic [countWidth-1:0] cfg_num_vectors_i,
    input  logic                  valid_i,
    input  logic [wordBits-1:0]   data_i,
    output logic                  ready_o,
    output logic                  wr_en_o,
    output logic [addrWidth-1:0]  wr_addr_o,
    output logic [wordBits-1:0]   wr_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            width_q, width_d;
    logic [countWidth-1:0] num_q, num_d;
    logic [countWidth-1:0] cnt_q, cnt_d;
    logic [1:0]            slot_q, slot_d;
    logic [wordBits-1:0]   pack_q, pack_d;
    logic [addrWidth-1:0]  addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [addrWidth-1:0]  wr_addr_q, wr_addr_d;
    logic [wordBits-1:0]   wr_data_q, wr_data_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [wordBits-1:0]   comp2, comp4, comp8, new_bits, merged;
    logic [1:0]            last_slot;
    logic                  last_vec;

    // Element-wise truncation to the n LSBs for each supported width.
    always_comb begin
        comp2 = '0;
        comp4 = '0;
        comp8 = '0;
        for (int unsigned e = 0; e < numElements; e++) begin
            comp2[e*2 +: 2] = data_i[e*elementBits +: 2];
            comp4[e*4 +: 4] = data_i[e*elementBits +: 4];
            comp8[e*8 +: 8] = data_i[e*elementBits +: 8];
        end
        case (width_q)
            4'd2: begin
                new_bits  = comp2 << (32'(slot_q) * numElements * 2);
                last_slot = 2'd3;
            end
            4'd4: begin
                new_bits  = comp4 << (32'(slot_q) * numElements * 4);
                last_slot = 2'd1;
            end
            default: begin
                new_bits  = comp8;
                last_slot = 2'd0;
            end
        endcase
        merged = pack_q | new_bits;
    end

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        num_d     = num_q;
        cnt_d     = cnt_q;
        slot_d    = slot_q;
        pack_d    = pack_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        last_vec  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    case (cfg_out_bits_i)
                        4'd2:    width_d = 4'd2;
                        4'd4:    width_d = 4'd4;
                        default: width_d = 4'd8;
                    endcase
                    num_d   = cfg_num_vectors_i;
                    addr_d  = cfg_base_addr_i;
                    cnt_d   = '0;
                    slot_d  = '0;
                    pack_d  = '0;
                    state_d = (cfg_num_vectors_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (valid_i) begin
                    cnt_d    = cnt_q + countWidth'(1);
                    last_vec = (cnt_d == num_q);
                    if (slot_q == last_slot || last_vec) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = merged;
                        wr_addr_d = addr_q;
                        addr_d    = addr_q + addrWidth'(wordBytes);
                        pack_d    = '0;
                        slot_d    = '0;
                    end else begin
                        pack_d = merged;
                        slot_d = slot_q + 2'd1;
                    end
                    if (last_vec) state_d = FLUSH;
                end
            end
            // First FLUSH cycle carries the final write; the second is the idle flush cycle.
            FLUSH: begin
                if (!wr_en_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (clear_i) begin
            state_d = IDLE;
            pack_d  = '0;
            cnt_d   = '0;
            slot_d  = '0;
            wr_en_d = 1'b0;
        end

        ready_d = (state_d == RUN);
        busy_d  = (state_d == RUN) || (state_d == FLUSH);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            width_q   <= '0;
            num_q     <= '0;
            cnt_q     <= '0;
            slot_q    <= '0;
            pack_q    <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            num_q     <= num_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            pack_q    <= pack_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ready_o   = ready_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_output_packer.sv
// Directed bench for output_packer: fixed-latency steps with hand-computed words.
module tb_output_packer;

    logic         clk = 1'b0;
    logic         nrst;
    logic         start_i;
    logic         clear_i;
    logic [3:0]   cfg_out_bits_i;
    logic [31:0]  cfg_base_addr_i;
    logic [15:0]  cfg_num_vectors_i;
    logic         valid_i;
    logic [255:0] data_i;
    logic         ready_o;
    logic         wr_en_o;
    logic [31:0]  wr_addr_o;
    logic [255:0] wr_data_o;
    logic         busy_o;
    logic         done_o;

    int compared   = 0;
    int mismatched = 0;

    output_packer #(
        .numElements(32),
        .elementBits(8),
        .addrWidth(32),
        .countWidth(16)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .start_i(start_i),
        .clear_i(clear_i),
        .cfg_out_bits_i(cfg_out_bits_i),
        .cfg_base_addr_i(cfg_base_addr_i),
        .cfg_num_vectors_i(cfg_num_vectors_i),
        .valid_i(valid_i),
        .data_i(data_i),
        .ready_o(ready_o),
        .wr_en_o(wr_en_o),
        .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [3:0] bits, input logic [31:0] base, input logic [15:0] n);
        start_i           = 1'b1;
        cfg_out_bits_i    = bits;
        cfg_base_addr_i   = base;
        cfg_num_vectors_i = n;
        tick();
        start_i = 1'b0;
    endtask

    task automatic vec(input logic [7:0] b);
        valid_i = 1'b1;
        data_i  = {32{b}};
    endtask

    initial begin
        nrst = 1'b0; start_i = 1'b0; clear_i = 1'b0; valid_i = 1'b0;
        cfg_out_bits_i = '0; cfg_base_addr_i = '0; cfg_num_vectors_i = '0; data_i = '0;
        #1;
        check("rst_ready", 256'(ready_o), 256'd0);
        check("rst_wr_en", 256'(wr_en_o), 256'd0);
        check("rst_addr", 256'(wr_addr_o), 256'd0);
        check("rst_data", wr_data_o, 256'd0);
        check("rst_busy_done", {254'd0, busy_o, done_o}, 256'd0);
        tick(); tick();
        nrst = 1'b1;

        // valid outside RUN is ignored
        vec(8'h99);
        tick();
        check("idle_valid_no_wr", 256'(wr_en_o), 256'd0);
        valid_i = 1'b0;

        // width 8, base 0x100, N=3
        start_job(4'd8, 32'h100, 16'd3);
        check("w8_ready", 256'(ready_o), 256'd1);
        check("w8_busy", 256'(busy_o), 256'd1);
        vec(8'h11); tick();
        check("w8_wr0_en", 256'(wr_en_o), 256'd1);
        check("w8_wr0_addr", 256'(wr_addr_o), 256'h100);
        check("w8_wr0_data", wr_data_o, {32{8'h11}});
        vec(8'h22); tick();
        check("w8_wr1_addr", 256'(wr_addr_o), 256'h120);
        check("w8_wr1_data", wr_data_o, {32{8'h22}});
        vec(8'h33); tick();
        check("w8_wr2_en", 256'(wr_en_o), 256'd1);
        check("w8_wr2_addr", 256'(wr_addr_o), 256'h140);
        check("w8_wr2_data", wr_data_o, {32{8'h33}});
        check("w8_ready_after_last", 256'(ready_o), 256'd0);
        valid_i = 1'b0; tick();
        check("w8_flush_no_wr", 256'(wr_en_o), 256'd0);
        check("w8_flush_busy", {254'd0, busy_o, done_o}, 256'b10);
        tick();
        check("w8_done", {254'd0, busy_o, done_o}, 256'b01);
        tick();
        check("w8_done_pulse_end", 256'(done_o), 256'd0);

        // width 4, base 0x200, N=3
        start_job(4'd4, 32'h200, 16'd3);
        vec(8'hA5); tick();
        check("w4_no_wr_half", 256'(wr_en_o), 256'd0);
        vec(8'h03); tick();
        check("w4_wr0_en", 256'(wr_en_o), 256'd1);
        check("w4_wr0_addr", 256'(wr_addr_o), 256'h200);
        check("w4_wr0_data", wr_data_o, {{32{4'h3}}, {32{4'h5}}});
        vec(8'h0F); tick();
        check("w4_wr1_en", 256'(wr_en_o), 256'd1);
        check("w4_wr1_addr", 256'(wr_addr_o), 256'h220);
        check("w4_wr1_data", wr_data_o, {128'd0, {32{4'hF}}});
        valid_i = 1'b0; tick();
        check("w4_flush_no_wr", 256'(wr_en_o), 256'd0);
        tick();
        check("w4_done", 256'(done_o), 256'd1);
        tick();

        // width 2, N=4, valid every other cycle
        start_job(4'd2, 32'h0, 16'd4);
        begin
            logic [7:0] pat [4] = '{8'h01, 8'h06, 8'hFF, 8'h04};
            int wr_seen = 0;
            for (int k = 0; k < 4; k++) begin
                vec(pat[k]); tick();
                if (k < 3) begin
                    wr_seen += int'(wr_en_o);
                    valid_i = 1'b0; tick();
                    wr_seen += int'(wr_en_o);
                end
            end
            check("w2_no_early_wr", 256'(wr_seen), 256'd0);
        end
        check("w2_wr_en", 256'(wr_en_o), 256'd1);
        check("w2_wr_addr", 256'(wr_addr_o), 256'h0);
        check("w2_wr_data", wr_data_o, {64'd0, {16{4'hF}}, {16{4'hA}}, {16{4'h5}}});
        valid_i = 1'b0; tick();
        check("w2_flush_no_wr", 256'(wr_en_o), 256'd0);
        tick();
        check("w2_done", 256'(done_o), 256'd1);
        tick();

        // N=0 with illegal width
        start_job(4'd5, 32'h300, 16'd0);
        check("n0_done", 256'(done_o), 256'd1);
        check("n0_no_wr_busy", {254'd0, wr_en_o, busy_o}, 256'd0);
        tick();
        check("n0_done_end", 256'(done_o), 256'd0);

        // illegal width 5 packs as 8
        start_job(4'd5, 32'h340, 16'd1);
        vec(8'h5A); tick();
        check("w5_wr_en", 256'(wr_en_o), 256'd1);
        check("w5_wr_data", wr_data_o, {32{8'h5A}});
        valid_i = 1'b0; tick(); tick();
        check("w5_done", 256'(done_o), 256'd1);
        tick();

        // clear mid-job with simultaneous start
        start_job(4'd4, 32'h380, 16'd2);
        vec(8'hA5); tick();
        clear_i = 1'b1; start_i = 1'b1; cfg_base_addr_i = 32'h999; cfg_num_vectors_i = 16'd1;
        vec(8'h03); tick();
        check("clr_wr_en", 256'(wr_en_o), 256'd0);
        check("clr_idle", {253'd0, ready_o, busy_o, done_o}, 256'd0);
        clear_i = 1'b0; start_i = 1'b0; tick();
        check("clr_stay_idle", {253'd0, wr_en_o, busy_o, done_o}, 256'd0);
        valid_i = 1'b0;
        start_job(4'd4, 32'h400, 16'd2);
        vec(8'hA5); tick();
        check("post_clr_no_wr", 256'(wr_en_o), 256'd0);
        vec(8'h03); tick();
        check("post_clr_addr", 256'(wr_addr_o), 256'h400);
        check("post_clr_data", wr_data_o, {{32{4'h3}}, {32{4'h5}}});
        valid_i = 1'b0; tick(); tick();
        check("post_clr_done", 256'(done_o), 256'd1);
        tick();

        // async reset mid-job
        start_job(4'd8, 32'h500, 16'd3);
        vec(8'h44); tick();
        check("pre_rst_wr", 256'(wr_en_o), 256'd1);
        nrst = 1'b0; #1;
        check("mid_rst_ctrl", {252'd0, ready_o, wr_en_o, busy_o, done_o}, 256'd0);
        check("mid_rst_addr", 256'(wr_addr_o), 256'd0);
        check("mid_rst_data", wr_data_o, 256'd0);
        #2; nrst = 1'b1;
        begin
            int wr_after = 0;
            for (int c = 0; c < 4; c++) begin
                tick();
                wr_after += int'(wr_en_o) + int'(busy_o);
            end
            check("post_rst_no_wr", 256'(wr_after), 256'd0);
        end
        valid_i = 1'b0;

        // address wrap
        start_job(4'd8, 32'hFFFFFFE0, 16'd2);
        vec(8'h77); tick();
        check("wrap_addr0", 256'(wr_addr_o), 256'hFFFFFFE0);
        vec(8'h88); tick();
        check("wrap_addr1", 256'(wr_addr_o), 256'h0);
        check("wrap_data1", wr_data_o, {32{8'h88}});
        valid_i = 1'b0; tick(); tick();
        check("wrap_done", 256'(done_o), 256'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
